imm_extender_pipe: RTL and testbench

Registered, parametrised immediate extender for the SimpleProcessor decode/execute boundary. Takes an N-bit immediate and produces an M-bit operand in one of four modes: zero-extend, sign-extend, sign-extend shifted left by 2 for branch offsets, and upper placement for LUI. It sits behind a valid/ready handshake with a 2-entry skid buffer, so downstream stalls never drop or duplicate an immediate.

---
 rtl/imm_ext_pkg.sv | 12 +
 rtl/imm_extend_core.sv | 36 +++
 rtl/imm_extender_pipe.sv | 98 +++++++++
 tb/tb_imm_extender_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate extender.
package imm_ext_pkg;

  // Extension mode, carried alongside the immediate.
  typedef enum logic [1:0] {
    MODE_ZERO  = 2'b00,
    MODE_SIGN  = 2'b01,
    MODE_SHL2  = 2'b10,
    MODE_UPPER = 2'b11
  } imm_mode_t;

endpackage : imm_ext_pkg

// File: rtl/imm_extend_core.sv
// Pure combinational immediate extension: N-bit immediate -> M-bit operand.
module imm_extend_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 32
) (
  input  logic [N-1:0] i_data,
  input  logic [1:0]   i_mode,
  output logic [M-1:0] o_data
);

  // Reject widths that would lose the sign bit in the shifted mode.
  if (N < 2 || M < N + 2) begin : g_bad_params
    $error("imm_extend_core: need N >= 2 and M - N >= 2");
  end

  imm_mode_t       mode;
  logic [M-1:0]    sext;

  assign mode = imm_mode_t'(i_mode);

  // Select the extended operand for the requested mode.
  always_comb begin
    sext   = {{(M-N){i_data[N-1]}}, i_data};
    o_data = '0;
    case (mode)
      MODE_ZERO:  o_data = {{(M-N){1'b0}}, i_data};
      MODE_SIGN:  o_data = sext;
      MODE_SHL2:  o_data = {sext[M-3:0], 2'b00};
      MODE_UPPER: o_data = {i_data, {(M-N){1'b0}}};
      default:    o_data = '0;
    endcase
  end

endmodule : imm_extend_core

// File: rtl/imm_extender_pipe.sv
// Registered immediate extender behind a valid/ready handshake with a
// 2-entry skid buffer (output register + skid register).
module imm_extender_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_data,
  input  logic [1:0]   i_mode,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_data,
  output logic         o_neg
);

  logic [M-1:0] ext;

  logic         out_valid_q, out_valid_d;
  logic [M-1:0] out_data_q,  out_data_d;
  logic         out_neg_q,   out_neg_d;
  logic         skid_valid_q, skid_valid_d;
  logic [M-1:0] skid_data_q,  skid_data_d;

  logic accept;
  logic xfer;

  imm_extend_core #(
    .N (N),
    .M (M)
  ) u_core (
    .i_data (i_data),
    .i_mode (i_mode),
    .o_data (ext)
  );

  // Ready depends only on skid state, so there is no path from i_ready.
  assign o_ready = !skid_valid_q;
  assign o_valid = out_valid_q;
  assign o_data  = out_data_q;
  assign o_neg   = out_neg_q;

  assign accept = i_valid && o_ready;
  assign xfer   = out_valid_q && i_ready;

  // Next-state for output and skid registers.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (skid_valid_q && (xfer || !out_valid_q)) begin
      // Skid drains into the output register; a simultaneous accept
      // (only possible if state is inconsistent) refills the skid.
      out_valid_d  = 1'b1;
      out_data_d   = skid_data_q;
      skid_valid_d = accept;
      if (accept) begin
        skid_data_d = ext;
      end
    end else if (xfer || !out_valid_q) begin
      // Output register is free this edge.
      out_valid_d = accept;
      if (accept) begin
        out_data_d = ext;
      end
    end else if (accept) begin
      // Output held by a stall: park the new result in the skid.
      skid_valid_d = 1'b1;
      skid_data_d  = ext;
    end

    out_neg_d = out_data_d[M-1];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_neg_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_neg_q    <= out_neg_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule : imm_extender_pipe

// File: tb/tb_imm_extender_pipe.sv
// Self-checking bench for imm_extender_pipe (N=16, M=32).
module tb_imm_extender_pipe;
  import imm_ext_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        ds_ready;
  logic [31:0] out_data;
  logic        out_neg;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [31:0] exp_q[$];

  imm_extender_pipe #(
    .N (16),
    .M (32)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_data  (in_data),
    .i_mode  (in_mode),
    .o_valid (out_valid),
    .i_ready (ds_ready),
    .o_data  (out_data),
    .o_neg   (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference extension written arithmetically, independent of bit slicing.
  function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
    case (m)
      2'b00:   return {16'h0000, d};
      2'b01:   return 32'($signed(d));
      2'b10:   return 32'($signed(d)) << 2;
      default: return {d, 16'h0000};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [31:0] e;
    logic        n;
  } vec_t;

  vec_t vecs[5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h5555;
    in_mode  = MODE_SIGN;
    ds_ready = 1'b1;

    // 1. Reset with i_valid asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'h0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check("post_rst_ready", 32'(out_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // 2. Mode vectors, hand-computed.
    vecs[0] = '{16'h8001, MODE_ZERO,  32'h00008001, 1'b0};
    vecs[1] = '{16'h8001, MODE_SIGN,  32'hFFFF8001, 1'b1};
    vecs[2] = '{16'h8001, MODE_SHL2,  32'hFFFE0004, 1'b1};
    vecs[3] = '{16'h1234, MODE_UPPER, 32'h12340000, 1'b0};
    vecs[4] = '{16'h7FFF, MODE_SIGN,  32'h00007FFF, 1'b0};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].d;
      in_mode  = vecs[i].m;
      tick();
      in_valid = 1'b0;
      check("mode_valid", 32'(out_valid), 32'd1);
      check("mode_data", out_data, vecs[i].e);
      check("mode_neg", 32'(out_neg), 32'(vecs[i].n));
    end
    tick();
    check("mode_drained", 32'(out_valid), 32'd0);

    // 3. Back-to-back streaming.
    in_mode = MODE_ZERO;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100 + 16'(i);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", out_data, 32'h00000100 + 32'(i));
      check("stream_ready", 32'(out_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end", 32'(out_valid), 32'd0);

    // 4. Stall with skid fill.
    in_mode  = MODE_SIGN;
    ds_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0001;
    tick();
    check("stall_d1", out_data, 32'h1);
    check("stall_rdy1", 32'(out_ready), 32'd1);
    in_data = 16'h0002;
    tick();
    check("stall_rdy2", 32'(out_ready), 32'd0);
    check("stall_hold", out_data, 32'h1);
    in_data = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rdy_low", 32'(out_ready), 32'd0);
      check("stall_stable", out_data, 32'h1);
      check("stall_vld", 32'(out_valid), 32'd1);
    end
    ds_ready = 1'b1;
    tick();
    check("unstall_d2", out_data, 32'h2);
    check("unstall_rdy", 32'(out_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("unstall_d3", out_data, 32'h3);
    tick();
    check("unstall_empty", 32'(out_valid), 32'd0);

    // 5. Random traffic against a reference queue.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      check("rnd_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("rnd_ready", 32'(out_ready), 32'(exp_q.size() < 2));
      in_valid = 1'($urandom);
      ds_ready = 1'($urandom);
      in_data  = 16'($urandom);
      in_mode  = 2'($urandom_range(3));
      if (out_valid && ds_ready && exp_q.size() != 0) begin
        check("rnd_data", out_data, exp_q[0]);
        check("rnd_neg", 32'(out_neg), 32'(exp_q[0][31]));
        void'(exp_q.pop_front());
      end
      if (in_valid && out_ready) begin
        exp_q.push_back(model(in_data, in_mode));
      end
      tick();
    end
    in_valid = 1'b0;
    ds_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      if (out_valid) begin
        check("drain_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      tick();
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    // 6. Reset while two results are held.
    ds_ready = 1'b0;
    in_valid = 1'b1;
    in_mode  = MODE_ZERO;
    in_data  = 16'hAAAA;
    tick();
    in_data = 16'hBBBB;
    tick();
    check("pre_rst_full", 32'(out_ready), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(out_ready), 32'd1);
    check("mid_rst_data", out_data, 32'h0);
    ds_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_gone", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imm_extender_pipe
